vga_char_shifter: RTL and testbench

- Text-mode pixel serializer directly downstream of the VGA timing/memory controller.
- Captures the character-generator font byte on the controller's parallel-load strobe and shifts it out one bit per pixel on the controller's pixel clock.
- Applies attribute blink and a hardware cursor, and drives the `charpixel` signal back into the controller, where it selects the foreground or background colour latch.
- In graphics modes the block is idle and holds `charpixel` low.

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_edge_det.sv | 27 ++
 rtl/vga_char_shifter.sv | 117 +++++++++++
 tb/tb_vga_char_shifter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared widths and mode encodings for the text-mode pixel path.
// Revision : 1.0  initial release
// ============================================================================
package vga_pkg;

  localparam int DEFAULT_FONT_W = 8;
  localparam int DEFAULT_CNT_W  = 6;
  localparam int CROW_W         = 4;

  typedef enum logic {
    MODE_TEXT = 1'b0,
    MODE_GFX  = 1'b1
  } mode_e;

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : vga_edge_det
// Purpose  : Single-bit registered rising-edge detector on the system clock.
// Revision : 1.0  initial release
// ============================================================================
module vga_edge_det (
  input  logic clock,
  input  logic reset,
  input  logic din,
  output logic rise
);

  logic r_din_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_din_d <= 1'b0;
    end else begin
      r_din_d <= din;
    end
  end

  assign rise = din & ~r_din_d;

endmodule : vga_edge_det
`default_nettype wire

// File: rtl/vga_char_shifter.sv
`default_nettype none
// ============================================================================
// Module   : vga_char_shifter
// Purpose  : Text-mode font serializer with attribute blink and cursor overlay.
// Revision : 1.0  initial release
// ============================================================================
module vga_char_shifter
  import vga_pkg::*;
#(
  parameter int FONT_W = DEFAULT_FONT_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              px_clk,
  input  logic              _pe_chpx,
  input  logic              _charmode,
  input  logic [FONT_W-1:0] font_data,
  input  logic              blink_attr,
  input  logic              cursor_hit,
  input  logic              cursor_en,
  input  logic [CROW_W-1:0] chrow,
  input  logic [CROW_W-1:0] cur_start,
  input  logic [CROW_W-1:0] cur_end,
  input  logic              vsync,
  output logic              charpixel,
  output logic              blink_phase
);

  logic              w_px_rise;
  logic              w_vs_rise;

  logic [FONT_W-1:0] r_sreg;
  logic              r_blink_l;
  logic              r_curs_l;
  logic [CROW_W-1:0] r_row_l;
  logic [CNT_W-1:0]  r_frame_cnt;

  logic [FONT_W-1:0] w_sreg_nx;
  logic              w_blink_nx;
  logic              w_curs_nx;
  logic [CROW_W-1:0] w_row_nx;
  logic [CNT_W-1:0]  w_frame_nx;
  logic              w_cur_on;
  logic              w_in_win;
  logic              w_pix_nx;

  vga_edge_det u_px_det (
    .clock (clock),
    .reset (reset),
    .din   (px_clk),
    .rise  (w_px_rise)
  );

  vga_edge_det u_vs_det (
    .clock (clock),
    .reset (reset),
    .din   (vsync),
    .rise  (w_vs_rise)
  );

  always_comb begin
    w_sreg_nx  = r_sreg;
    w_blink_nx = r_blink_l;
    w_curs_nx  = r_curs_l;
    w_row_nx   = r_row_l;
    w_frame_nx = r_frame_cnt;

    if (mode_e'(_charmode) == MODE_GFX) begin
      w_sreg_nx  = '0;
      w_blink_nx = 1'b0;
      w_curs_nx  = 1'b0;
    end else if (w_px_rise) begin
      if (!_pe_chpx) begin
        w_sreg_nx  = font_data;
        w_blink_nx = blink_attr;
        w_curs_nx  = cursor_hit & cursor_en;
        w_row_nx   = chrow;
      end else begin
        w_sreg_nx  = {r_sreg[FONT_W-2:0], 1'b0};
      end
    end

    if (w_vs_rise) begin
      w_frame_nx = r_frame_cnt + CNT_W'(1);
    end
  end

  // The pixel is registered from next-state values so the output carries the
  // same cycle timing as the shifter while having no path from any input.
  assign w_cur_on = ~w_frame_nx[CNT_W-2];
  assign w_in_win = (cur_start <= w_row_nx) && (w_row_nx <= cur_end);
  assign w_pix_nx = (w_sreg_nx[FONT_W-1] & ~(w_blink_nx & w_frame_nx[CNT_W-1]))
                  | (w_curs_nx & w_cur_on & w_in_win);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sreg      <= '0;
      r_blink_l   <= 1'b0;
      r_curs_l    <= 1'b0;
      r_row_l     <= '0;
      r_frame_cnt <= '0;
      charpixel   <= 1'b0;
      blink_phase <= 1'b0;
    end else begin
      r_sreg      <= w_sreg_nx;
      r_blink_l   <= w_blink_nx;
      r_curs_l    <= w_curs_nx;
      r_row_l     <= w_row_nx;
      r_frame_cnt <= w_frame_nx;
      charpixel   <= w_pix_nx;
      blink_phase <= w_frame_nx[CNT_W-1];
    end
  end

endmodule : vga_char_shifter
`default_nettype wire

// File: tb/tb_vga_char_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vga_char_shifter
// Purpose  : Directed scoreboard bench for the text-mode pixel serializer.
// Revision : 1.0  initial release
// ============================================================================
module tb_vga_char_shifter;

  logic       clock;
  logic       reset;
  logic       px_clk;
  logic       _pe_chpx;
  logic       _charmode;
  logic [7:0] font_data;
  logic       blink_attr;
  logic       cursor_hit;
  logic       cursor_en;
  logic [3:0] chrow;
  logic [3:0] cur_start;
  logic [3:0] cur_end;
  logic       vsync;
  logic       charpixel;
  logic       blink_phase;

  typedef struct {
    logic  cp;
    logic  bp;
    logic  chk_bp;
    string tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  logic a5_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  vga_char_shifter dut (
    .clock       (clock),
    .reset       (reset),
    .px_clk      (px_clk),
    ._pe_chpx    (_pe_chpx),
    ._charmode   (_charmode),
    .font_data   (font_data),
    .blink_attr  (blink_attr),
    .cursor_hit  (cursor_hit),
    .cursor_en   (cursor_en),
    .chrow       (chrow),
    .cur_start   (cur_start),
    .cur_end     (cur_end),
    .vsync       (vsync),
    .charpixel   (charpixel),
    .blink_phase (blink_phase)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic expect_out(input logic cp, input logic bp, input logic cbp, input string tag);
    exp_t e;
    e.cp = cp;
    e.bp = bp;
    e.chk_bp = cbp;
    e.tag = tag;
    sb.push_back(e);
  endtask

  // One pixel period: high for one clock (edge detected), then low for one.
  task automatic pix(input logic load, input logic [7:0] fd);
    px_clk    = 1'b1;
    _pe_chpx  = ~load;
    font_data = fd;
    @(posedge clock); #1;
    px_clk    = 1'b0;
    _pe_chpx  = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic vs_pulse();
    vsync = 1'b1;
    @(posedge clock); #1;
    vsync = 1'b0;
    @(posedge clock); #1;
  endtask

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (charpixel !== mon_e.cp || (mon_e.chk_bp && blink_phase !== mon_e.bp)) begin
        errors++;
        $display("FAIL %s: got charpixel=%0b blink_phase=%0b, expected charpixel=%0b blink_phase=%0b",
                 mon_e.tag, charpixel, blink_phase, mon_e.cp, mon_e.bp);
      end
    end
  end

  initial begin
    reset = 1'b1; px_clk = 1'b0; _pe_chpx = 1'b1; _charmode = 1'b0;
    font_data = 8'h00; blink_attr = 1'b0; cursor_hit = 1'b0; cursor_en = 1'b0;
    chrow = 4'd0; cur_start = 4'd0; cur_end = 4'd0; vsync = 1'b0;

    repeat (2) @(posedge clock); #1;
    expect_out(1'b0, 1'b0, 1'b1, "reset_state");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;

    // Serialization of 0xA5, then drain with no reload
    pix(1'b1, 8'hA5);
    expect_out(a5_seq[0], 1'b0, 1'b1, "a5_load");
    for (int i = 1; i < 8; i++) begin
      pix(1'b0, 8'h00);
      expect_out(a5_seq[i], 1'b0, 1'b1, "a5_shift");
    end
    pix(1'b0, 8'h00);
    expect_out(1'b0, 1'b0, 1'b1, "a5_drain");

    // Back-to-back cells 0xFF then 0x00
    for (int i = 0; i < 16; i++) begin
      pix((i % 8) == 0, (i < 8) ? 8'hFF : 8'h00);
      expect_out(i < 8, 1'b0, 1'b1, "b2b");
    end

    // Attribute blink across 64 frames (wraps back to frame 0)
    blink_attr = 1'b1;
    pix(1'b1, 8'hFF);
    expect_out(1'b1, 1'b0, 1'b1, "blink_load");
    for (int f = 1; f <= 64; f++) begin
      vs_pulse();
      if (f < 32 || f == 64) expect_out(1'b1, 1'b0, 1'b1, "blink_visible");
      else                   expect_out(1'b0, 1'b1, 1'b1, "blink_hidden");
    end
    blink_attr = 1'b0;

    // Cursor window rows 13..14, frame 0
    cursor_hit = 1'b1; cursor_en = 1'b1; cur_start = 4'd13; cur_end = 4'd14;
    for (int r = 11; r <= 15; r++) begin
      chrow = 4'(r);
      pix(1'b1, 8'h00);
      expect_out((r == 13) || (r == 14), 1'b0, 1'b1, "curs_window");
    end
    repeat (16) vs_pulse();
    chrow = 4'd13; pix(1'b1, 8'h00);
    expect_out(1'b0, 1'b0, 1'b1, "curs_off_phase_r13");
    chrow = 4'd14; pix(1'b1, 8'h00);
    expect_out(1'b0, 1'b0, 1'b1, "curs_off_phase_r14");
    repeat (16) vs_pulse();
    chrow = 4'd13; pix(1'b1, 8'h00);
    expect_out(1'b1, 1'b1, 1'b1, "curs_on_frame32");
    cur_start = 4'd14; cur_end = 4'd13;
    repeat (2) @(posedge clock); #1;
    chrow = 4'd13; pix(1'b1, 8'h00);
    expect_out(1'b0, 1'b1, 1'b1, "curs_empty_r13");
    chrow = 4'd14; pix(1'b1, 8'h00);
    expect_out(1'b0, 1'b1, 1'b1, "curs_empty_r14");
    cur_start = 4'd13; cur_end = 4'd14; cursor_en = 1'b0;
    chrow = 4'd13; pix(1'b1, 8'h00);
    expect_out(1'b0, 1'b1, 1'b1, "curs_disabled");
    cursor_en = 1'b1; blink_attr = 1'b1;
    pix(1'b1, 8'hFF);
    expect_out(1'b1, 1'b1, 1'b1, "curs_over_blink");
    cursor_hit = 1'b0;
    pix(1'b1, 8'hFF);
    expect_out(1'b0, 1'b1, 1'b1, "blink_hidden_nocurs");
    blink_attr = 1'b0;

    // Mode switch mid-cell
    pix(1'b1, 8'hFF);
    expect_out(1'b1, 1'b1, 1'b1, "mode_load");
    repeat (3) begin
      pix(1'b0, 8'h00);
      expect_out(1'b1, 1'b1, 1'b1, "mode_shift");
    end
    _charmode = 1'b1;
    @(posedge clock); #1;
    expect_out(1'b0, 1'b1, 1'b1, "gfx_clear");
    pix(1'b1, 8'hFF);
    expect_out(1'b0, 1'b1, 1'b1, "gfx_ignores_load");
    _charmode = 1'b0;
    pix(1'b0, 8'h00);
    expect_out(1'b0, 1'b1, 1'b1, "text_no_reload_1");
    pix(1'b0, 8'h00);
    expect_out(1'b0, 1'b1, 1'b1, "text_no_reload_2");

    // Reset at frame 40 mid-shift
    repeat (8) vs_pulse();
    pix(1'b1, 8'hFF);
    pix(1'b0, 8'h00);
    pix(1'b0, 8'h00);
    expect_out(1'b1, 1'b1, 1'b1, "pre_reset");
    reset = 1'b1;
    @(posedge clock); #1;
    expect_out(1'b0, 1'b0, 1'b1, "reset_mid_op");
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    pix(1'b0, 8'h00);
    expect_out(1'b0, 1'b0, 1'b1, "post_reset_idle");
    blink_attr = 1'b1;
    pix(1'b1, 8'hFF);
    expect_out(1'b1, 1'b0, 1'b1, "post_reset_load");
    for (int f = 1; f <= 32; f++) begin
      vs_pulse();
      if (f == 31) expect_out(1'b1, 1'b0, 1'b1, "post_reset_f31");
      if (f == 32) expect_out(1'b0, 1'b1, 1'b1, "post_reset_f32");
    end

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected entries left unchecked, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_vga_char_shifter
`default_nettype wire
